trace_monitor: RTL and testbench

- Synthesizable retire-trace and host-exit monitor inside the SoC, beside cpu.
- Captures up to NUM_CH single-cycle commit events (register, CSR, store and similar) from the execute stage into a buffered stream drained by valid/ready.
- Snoops the data-memory request bus for the host (tohost) write and latches the exit code.
- Enforces a programmable cycle limit, so the same halt/exit reporting works on FPGA and in simulation.

---
 rtl/trace_monitor_pkg.sv | 10 +
 rtl/trace_fifo.sv | 42 ++++
 rtl/trace_monitor.sv | 164 ++++++++++++++++
 tb/tb_trace_monitor.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trace_monitor_pkg.sv
// trace_monitor_pkg: shared defaults, FSM encoding and round-robin helper for trace_monitor.
package trace_monitor_pkg;
  localparam int TM_NUM_CH = 3;
  localparam int TM_FIFO_DEPTH = 16;
  localparam logic [31:0] TM_TOHOST = 32'h8000_1000;
  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_HALT} state_e;
  function automatic int rr_next(input int ch, input int n);
    return ch + 1 >= n ? 0 : ch + 1;
  endfunction
endpackage

// File: rtl/trace_fifo.sv
// trace_fifo: synchronous FIFO of type T; ports clock/reset, push/din, pop/dout, full/empty; dout reads from storage and is 0 when empty.
module trace_fifo #(
  parameter type T = logic [7:0],
  parameter int DEPTH = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic push,
  input  T     din,
  input  logic pop,
  output T     dout,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);
  T mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  assign full = cnt_q == (AW+1)'(DEPTH);
  assign empty = cnt_q == '0;
  assign dout = empty ? '0 : mem_q[rd_q];
  always_comb begin
    do_pop = pop && !empty;
    do_push = push && (!full || do_pop);
    wr_d = do_push ? wr_q + AW'(1) : wr_q;
    rd_d = do_pop ? rd_q + AW'(1) : rd_q;
    cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  always_ff @(posedge clock)
    if (do_push) mem_q[wr_q] <= din;
endmodule

// File: rtl/trace_monitor.sv
// trace_monitor: per-channel commit-event skids, round-robin into a trace FIFO drained by tr_valid/tr_ready, tohost exit detect and cycle limit.
// Ports: ev_* event channels in, mem_* snooped dmem bus, host_addr/max_cycles config, tr_* trace stream out, drop_count/done/timeout/exit_code/finish status.
// Build option TRACE_TIMESTAMP_EN: entries carry the cycle counter at capture on tr_time; otherwise tr_time is 0.
module trace_monitor
  import trace_monitor_pkg::*;
#(
  parameter int NUM_CH     = TM_NUM_CH,
  parameter int FIFO_DEPTH = TM_FIFO_DEPTH,
  parameter int DATA_W     = 32,
  parameter int CNT_W      = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        ev_valid,
  input  logic [NUM_CH*DATA_W-1:0] ev_pc,
  input  logic [NUM_CH*DATA_W-1:0] ev_addr,
  input  logic [NUM_CH*DATA_W-1:0] ev_data,
  input  logic [NUM_CH*4-1:0]      ev_strb,
  input  logic                     mem_valid,
  input  logic [31:0]              mem_addr,
  input  logic [3:0]               mem_wstrb,
  input  logic [31:0]              mem_wdata,
  input  logic [31:0]              host_addr,
  input  logic [CNT_W-1:0]         max_cycles,
  output logic                     tr_valid,
  input  logic                     tr_ready,
  output logic [2:0]               tr_ch,
  output logic [DATA_W-1:0]        tr_pc,
  output logic [DATA_W-1:0]        tr_addr,
  output logic [DATA_W-1:0]        tr_data,
  output logic [3:0]               tr_strb,
  output logic [CNT_W-1:0]         tr_time,
  output logic [CNT_W-1:0]         drop_count,
  output logic                     done,
  output logic                     timeout,
  output logic [31:0]              exit_code,
  output logic                     finish
);
  typedef struct packed {
    logic [2:0]        ch;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [3:0]        strb;
`ifdef TRACE_TIMESTAMP_EN
    logic [CNT_W-1:0]  stamp;
`endif
  } trace_event_type;
  state_e state_q, state_d;
  trace_event_type skid_q [NUM_CH];
  trace_event_type skid_d [NUM_CH];
  trace_event_type fifo_din, fifo_dout;
  logic [NUM_CH-1:0] sv_q, sv_d;
  logic [2:0] rr_q, rr_d, gnt_ch;
  logic gnt_v, push_ok, pop, fifo_full, fifo_empty, run, host_hit, to_hit;
  int best;
  logic [3:0] ndrop;
  logic [CNT_W:0] dsum;
  logic [CNT_W-1:0] cnt_q, cnt_d, drop_q, drop_d;
  logic done_q, done_d, timeout_q, timeout_d;
  logic [31:0] exit_q, exit_d;
  logic unused_addr_lsb;
  assign run = state_q == ST_RUN;
  assign pop = !fifo_empty && tr_ready;
  assign push_ok = !fifo_full || pop;
  // Pick the occupied skid closest after the pointer; rr_q is the first channel to consider.
  always_comb begin
    gnt_v = 1'b0;
    gnt_ch = '0;
    best = NUM_CH;
    fifo_din = '0;
    for (int c = 0; c < NUM_CH; c++)
      if (push_ok && sv_q[c] && (c - int'(rr_q) + NUM_CH) % NUM_CH < best) begin
        best = (c - int'(rr_q) + NUM_CH) % NUM_CH;
        gnt_v = 1'b1;
        gnt_ch = 3'(c);
        fifo_din = skid_q[c];
      end
    rr_d = gnt_v ? 3'(rr_next(int'(gnt_ch), NUM_CH)) : rr_q;
  end
  // A skid emptied by this cycle's grant can take a new event in the same cycle.
  always_comb begin
    sv_d = sv_q;
    ndrop = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      skid_d[c] = skid_q[c];
      if (gnt_v && gnt_ch == 3'(c)) sv_d[c] = 1'b0;
      if (run && ev_valid[c] && sv_d[c]) ndrop = ndrop + 4'd1;
      else if (run && ev_valid[c]) begin
        sv_d[c] = 1'b1;
        skid_d[c].ch = 3'(c);
        skid_d[c].pc = ev_pc[c*DATA_W +: DATA_W];
        skid_d[c].addr = ev_addr[c*DATA_W +: DATA_W];
        skid_d[c].data = ev_data[c*DATA_W +: DATA_W];
        skid_d[c].strb = ev_strb[c*4 +: 4];
`ifdef TRACE_TIMESTAMP_EN
        skid_d[c].stamp = cnt_q;
`endif
      end
    end
  end
  // Host write wins over a timeout landing in the same cycle.
  always_comb begin
    host_hit = run && mem_valid && mem_addr[31:2] == host_addr[31:2] && |mem_wstrb;
    to_hit = run && max_cycles != '0 && cnt_q == max_cycles - CNT_W'(1);
    done_d = done_q || host_hit;
    timeout_d = timeout_q || (to_hit && !host_hit);
    exit_d = host_hit ? mem_wdata : exit_q;
    cnt_d = run ? cnt_q + CNT_W'(1) : cnt_q;
    dsum = {1'b0, drop_q} + (CNT_W+1)'(ndrop);
    drop_d = dsum[CNT_W] ? '1 : dsum[CNT_W-1:0];
    state_d = run && (host_hit || to_hit) ? ST_DRAIN
            : state_q == ST_DRAIN && sv_q == '0 && fifo_empty ? ST_HALT : state_q;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state_q <= ST_RUN;
      sv_q <= '0;
      rr_q <= '0;
      cnt_q <= '0;
      drop_q <= '0;
      done_q <= 1'b0;
      timeout_q <= 1'b0;
      exit_q <= '0;
      for (int c = 0; c < NUM_CH; c++) skid_q[c] <= '0;
    end else begin
      state_q <= state_d;
      sv_q <= sv_d;
      rr_q <= rr_d;
      cnt_q <= cnt_d;
      drop_q <= drop_d;
      done_q <= done_d;
      timeout_q <= timeout_d;
      exit_q <= exit_d;
      for (int c = 0; c < NUM_CH; c++) skid_q[c] <= skid_d[c];
    end
  trace_fifo #(.T(trace_event_type), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clock(clock),
    .reset(reset),
    .push(gnt_v),
    .din(fifo_din),
    .pop(pop),
    .dout(fifo_dout),
    .full(fifo_full),
    .empty(fifo_empty)
  );
  assign tr_valid = !fifo_empty;
  assign tr_ch = fifo_dout.ch;
  assign tr_pc = fifo_dout.pc;
  assign tr_addr = fifo_dout.addr;
  assign tr_data = fifo_dout.data;
  assign tr_strb = fifo_dout.strb;
`ifdef TRACE_TIMESTAMP_EN
  assign tr_time = fifo_dout.stamp;
`else
  assign tr_time = '0;
`endif
  assign drop_count = drop_q;
  assign done = done_q;
  assign timeout = timeout_q;
  assign exit_code = exit_q;
  assign finish = state_q == ST_HALT;
  assign unused_addr_lsb = ^{mem_addr[1:0], host_addr[1:0]};
endmodule

// File: tb/tb_trace_monitor.sv
// tb_trace_monitor: directed and randomized checks of trace_monitor against a queue-based reference model.
module tb_trace_monitor;
  import trace_monitor_pkg::*;
  localparam int N = 3;
  localparam int D = 16;
  localparam int W = 32;
  localparam int C = 32;
  typedef struct {
    int ch;
    logic [W-1:0] pc;
    logic [W-1:0] addr;
    logic [W-1:0] data;
    logic [3:0] strb;
    logic [C-1:0] ts;
  } ent_t;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [N-1:0] ev_valid = '0;
  logic [N*W-1:0] ev_pc = '0;
  logic [N*W-1:0] ev_addr = '0;
  logic [N*W-1:0] ev_data = '0;
  logic [N*4-1:0] ev_strb = '0;
  logic mem_valid = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [3:0] mem_wstrb = '0;
  logic [31:0] mem_wdata = '0;
  logic [31:0] host_addr = TM_TOHOST;
  logic [C-1:0] max_cycles = '0;
  logic tr_ready = 1'b0;
  logic tr_valid, done, timeout, finish;
  logic [2:0] tr_ch;
  logic [W-1:0] tr_pc, tr_addr, tr_data;
  logic [3:0] tr_strb;
  logic [C-1:0] tr_time, drop_count;
  logic [31:0] exit_code;
  ent_t mq[$];
  ent_t msk [N];
  bit mskv [N];
  int mrr, mst;
  logic [C-1:0] mcnt, mdrop;
  logic [31:0] mexit;
  bit mdone, mto;
  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  trace_monitor #(.NUM_CH(N), .FIFO_DEPTH(D), .DATA_W(W), .CNT_W(C)) dut (
    .clock(clock), .reset(reset),
    .ev_valid(ev_valid), .ev_pc(ev_pc), .ev_addr(ev_addr), .ev_data(ev_data), .ev_strb(ev_strb),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .host_addr(host_addr), .max_cycles(max_cycles),
    .tr_valid(tr_valid), .tr_ready(tr_ready), .tr_ch(tr_ch), .tr_pc(tr_pc), .tr_addr(tr_addr),
    .tr_data(tr_data), .tr_strb(tr_strb), .tr_time(tr_time),
    .drop_count(drop_count), .done(done), .timeout(timeout), .exit_code(exit_code), .finish(finish)
  );

  task automatic mreset();
    mq.delete();
    for (int c = 0; c < N; c++) mskv[c] = 1'b0;
    mrr = 0;
    mst = 0;
    mcnt = '0;
    mdrop = '0;
    mexit = '0;
    mdone = 1'b0;
    mto = 1'b0;
  endtask

  // One clock of the monitor's rules: pop, one round-robin transfer, capture/drop, exit detection, state.
  task automatic mstep();
    bit pop, space, idle, hh, th;
    int g;
    idle = mq.size() == 0;
    for (int c = 0; c < N; c++) if (mskv[c]) idle = 1'b0;
    pop = mq.size() > 0 && tr_ready;
    space = mq.size() < D || pop;
    g = -1;
    for (int k = 0; k < N; k++) if (space && g < 0 && mskv[(mrr + k) % N]) g = (mrr + k) % N;
    if (pop) void'(mq.pop_front());
    if (g >= 0) begin
      mq.push_back(msk[g]);
      mskv[g] = 1'b0;
      mrr = (g + 1) % N;
    end
    if (mst == 0)
      for (int c = 0; c < N; c++)
        if (ev_valid[c]) begin
          if (mskv[c]) begin
            if (mdrop != '1) mdrop++;
          end else begin
            mskv[c] = 1'b1;
            msk[c].ch = c;
            msk[c].pc = ev_pc[c*W +: W];
            msk[c].addr = ev_addr[c*W +: W];
            msk[c].data = ev_data[c*W +: W];
            msk[c].strb = ev_strb[c*4 +: 4];
`ifdef TRACE_TIMESTAMP_EN
            msk[c].ts = mcnt;
`else
            msk[c].ts = '0;
`endif
          end
        end
    hh = mst == 0 && mem_valid && mem_addr[31:2] == host_addr[31:2] && mem_wstrb != 4'b0;
    th = mst == 0 && max_cycles != '0 && mcnt == max_cycles - 1;
    if (hh) begin
      mdone = 1'b1;
      mexit = mem_wdata;
    end else if (th) mto = 1'b1;
    if (mst == 0) mcnt++;
    if (mst == 0 && (hh || th)) mst = 1;
    else if (mst == 1 && idle) mst = 2;
  endtask

  task automatic tick();
    @(posedge clock);
    if (reset) mreset();
    else mstep();
    #1;
  endtask

  task automatic clear_inputs();
    ev_valid = '0;
    mem_valid = 1'b0;
    mem_wstrb = '0;
    tr_ready = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic set_ev(input int c, input logic [W-1:0] pc, input logic [W-1:0] addr,
                        input logic [W-1:0] data, input logic [3:0] strb);
    ev_valid[c] = 1'b1;
    ev_pc[c*W +: W] = pc;
    ev_addr[c*W +: W] = addr;
    ev_data[c*W +: W] = data;
    ev_strb[c*4 +: 4] = strb;
  endtask

  task automatic host_write(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    mem_valid = 1'b1;
    mem_addr = a;
    mem_wstrb = s;
    mem_wdata = d;
  endtask

  task automatic test_reset();
    clear_inputs();
    max_cycles = '0;
    reset = 1'b1;
    tick();
    checks++;
    if (tr_valid !== 1'b0 || done !== 1'b0 || timeout !== 1'b0 || finish !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: tr_valid=%b done=%b timeout=%b finish=%b, want all 0", tr_valid, done, timeout, finish);
    end
    checks++;
    if (drop_count !== '0 || exit_code !== '0) begin
      errors++;
      $display("FAIL reset_counters: drop_count=%0d exit_code=%h, want 0", drop_count, exit_code);
    end
    checks++;
    if ({tr_ch, tr_pc, tr_addr, tr_data, tr_strb, tr_time} !== '0) begin
      errors++;
      $display("FAIL reset_fields: ch=%0d pc=%h addr=%h data=%h strb=%h time=%0d, want 0", tr_ch, tr_pc, tr_addr, tr_data, tr_strb, tr_time);
    end
    reset = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    tr_ready = 1'b1;
    set_ev(0, 32'h8000_0004, 32'd5, 32'h1234, 4'hf);
    tick();
    ev_valid = '0;
    checks++;
    if (tr_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_early: tr_valid=%b one cycle after event, want 0", tr_valid);
    end
    tick();
    checks++;
    if (tr_valid !== 1'b1) begin
      errors++;
      $display("FAIL single_latency: tr_valid=%b two cycles after event, want 1", tr_valid);
    end
    checks++;
    if (tr_ch !== 3'd0 || tr_pc !== 32'h8000_0004 || tr_addr !== 32'd5 || tr_data !== 32'h1234 || tr_strb !== 4'hf || tr_time !== '0) begin
      errors++;
      $display("FAIL single_fields: ch=%0d pc=%h addr=%h data=%h strb=%h time=%0d, want 0/80000004/5/1234/f/0", tr_ch, tr_pc, tr_addr, tr_data, tr_strb, tr_time);
    end
    tick();
    checks++;
    if (tr_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_pop: tr_valid=%b after accept, want 0", tr_valid);
    end
  endtask

  task automatic test_all_channels();
    do_reset();
    tr_ready = 1'b1;
    for (int c = 0; c < N; c++) set_ev(c, 32'h100 + 32'(c), 32'(c), 32'hA0 + 32'(c), 4'h1 << c);
    tick();
    ev_valid = '0;
    for (int k = 0; k < N; k++) begin
      tick();
      checks++;
      if (tr_valid !== 1'b1 || tr_ch !== 3'(k) || tr_data !== 32'hA0 + 32'(k)) begin
        errors++;
        $display("FAIL all_ch_order[%0d]: valid=%b ch=%0d data=%h, want 1/%0d/%h", k, tr_valid, tr_ch, tr_data, k, 32'hA0 + 32'(k));
      end
    end
    tick();
    checks++;
    if (tr_valid !== 1'b0 || drop_count !== '0) begin
      errors++;
      $display("FAIL all_ch_end: valid=%b drop_count=%0d, want 0/0", tr_valid, drop_count);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    tr_ready = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      set_ev(1, 32'h2000 + 32'(4 * i), 32'd3, 32'(i), 4'h3);
      tick();
      if (i >= 2) begin
        checks++;
        if (tr_valid !== 1'b1 || tr_pc !== 32'h2004 || tr_data !== 32'd1 || tr_ch !== 3'd1) begin
          errors++;
          $display("FAIL stall_stable[%0d]: valid=%b ch=%0d pc=%h data=%h, want 1/1/2004/1", i, tr_valid, tr_ch, tr_pc, tr_data);
        end
      end
    end
    ev_valid = '0;
    checks++;
    if (drop_count !== 32'd3) begin
      errors++;
      $display("FAIL b2b_drops: drop_count=%0d, want 3", drop_count);
    end
    tr_ready = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      checks++;
      if (tr_valid !== 1'b1 || tr_data !== 32'(i)) begin
        errors++;
        $display("FAIL b2b_drain[%0d]: valid=%b data=%0d, want 1/%0d", i, tr_valid, tr_data, i);
      end
      tick();
    end
    checks++;
    if (tr_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_empty: valid=%b after 17 pops, want 0", tr_valid);
    end
  endtask

  task automatic test_host_exit();
    int pops, k;
    do_reset();
    tr_ready = 1'b0;
    set_ev(0, 32'h10, 32'd1, 32'h11, 4'h0);
    set_ev(1, 32'h14, 32'd2, 32'h22, 4'h0);
    tick();
    ev_valid = '0;
    host_write(host_addr + 32'd2, 4'b0001, 32'h2A);
    tick();
    mem_valid = 1'b0;
    checks++;
    if (done !== 1'b1 || exit_code !== 32'h2A || timeout !== 1'b0 || finish !== 1'b0) begin
      errors++;
      $display("FAIL host_detect: done=%b exit=%h timeout=%b finish=%b, want 1/2a/0/0", done, exit_code, timeout, finish);
    end
    set_ev(2, 32'h18, 32'd3, 32'h33, 4'h0);
    host_write(host_addr, 4'b1111, 32'h55);
    tick();
    clear_inputs();
    tick();
    tick();
    checks++;
    if (exit_code !== 32'h2A || drop_count !== '0 || finish !== 1'b0 || tr_valid !== 1'b1) begin
      errors++;
      $display("FAIL host_drain_hold: exit=%h drops=%0d finish=%b valid=%b, want 2a/0/0/1", exit_code, drop_count, finish, tr_valid);
    end
    tr_ready = 1'b1;
    pops = 0;
    k = 0;
    while (finish !== 1'b1 && k < 20) begin
      if (tr_valid === 1'b1) begin
        checks++;
        if (tr_data !== (pops == 0 ? 32'h11 : 32'h22)) begin
          errors++;
          $display("FAIL host_entry[%0d]: data=%h, want %h", pops, tr_data, pops == 0 ? 32'h11 : 32'h22);
        end
        pops++;
      end
      tick();
      k++;
    end
    checks++;
    if (finish !== 1'b1 || pops != 2 || tr_valid !== 1'b0) begin
      errors++;
      $display("FAIL host_finish: finish=%b pops=%0d valid=%b, want 1/2/0", finish, pops, tr_valid);
    end
  endtask

  task automatic test_timeout();
    max_cycles = 32'd100;
    do_reset();
    repeat (99) tick();
    checks++;
    if (timeout !== 1'b0) begin
      errors++;
      $display("FAIL timeout_early: timeout=%b after 99 cycles, want 0", timeout);
    end
    tick();
    checks++;
    if (timeout !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL timeout_hit: timeout=%b done=%b after 100 cycles, want 1/0", timeout, done);
    end
    tick();
    checks++;
    if (finish !== 1'b1) begin
      errors++;
      $display("FAIL timeout_finish: finish=%b, want 1", finish);
    end
    do_reset();
    repeat (99) tick();
    host_write(host_addr, 4'b0100, 32'h77);
    tick();
    mem_valid = 1'b0;
    checks++;
    if (done !== 1'b1 || timeout !== 1'b0 || exit_code !== 32'h77) begin
      errors++;
      $display("FAIL timeout_vs_host: done=%b timeout=%b exit=%h, want 1/0/77", done, timeout, exit_code);
    end
    max_cycles = '0;
  endtask

  task automatic test_reset_in_drain();
    do_reset();
    tr_ready = 1'b0;
    set_ev(0, 32'h40, 32'd1, 32'h1, 4'h0);
    set_ev(1, 32'h44, 32'd2, 32'h2, 4'h0);
    tick();
    ev_valid = '0;
    host_write(host_addr, 4'b0010, 32'h99);
    tick();
    mem_valid = 1'b0;
    tick();
    checks++;
    if (tr_valid !== 1'b1 || done !== 1'b1) begin
      errors++;
      $display("FAIL drain_setup: valid=%b done=%b, want 1/1", tr_valid, done);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (tr_valid !== 1'b0 || done !== 1'b0 || finish !== 1'b0 || exit_code !== '0 || drop_count !== '0 || tr_data !== '0) begin
      errors++;
      $display("FAIL async_reset: valid=%b done=%b finish=%b exit=%h drops=%0d data=%h, want all 0", tr_valid, done, finish, exit_code, drop_count, tr_data);
    end
    tick();
    reset = 1'b0;
    set_ev(2, 32'h48, 32'd7, 32'hBEEF, 4'h5);
    tick();
    ev_valid = '0;
    tick();
    checks++;
    if (tr_valid !== 1'b1 || tr_ch !== 3'd2 || tr_data !== 32'hBEEF || tr_strb !== 4'h5) begin
      errors++;
      $display("FAIL post_reset_capture: valid=%b ch=%0d data=%h strb=%h, want 1/2/beef/5", tr_valid, tr_ch, tr_data, tr_strb);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int c = 0; c < N; c++)
        if ($urandom_range(0, 99) < 45) set_ev(c, $urandom, $urandom, $urandom, 4'($urandom));
        else ev_valid[c] = 1'b0;
      tr_ready = $urandom_range(0, 99) < (cyc < 300 ? 35 : 80);
      host_write(host_addr + 32'h40, 4'($urandom), $urandom);
      mem_valid = $urandom_range(0, 9) == 0;
      if (cyc == 450 || cyc == 500) host_write(host_addr + 32'd1, 4'b1000, $urandom);
      tick();
      checks++;
      if (tr_valid !== (mq.size() > 0)) begin
        errors++;
        $display("FAIL rnd_valid[%0d]: tr_valid=%b, want %b", cyc, tr_valid, mq.size() > 0);
      end else if (tr_valid && (tr_ch !== 3'(mq[0].ch) || tr_pc !== mq[0].pc || tr_addr !== mq[0].addr ||
                               tr_data !== mq[0].data || tr_strb !== mq[0].strb || tr_time !== mq[0].ts)) begin
        errors++;
        $display("FAIL rnd_entry[%0d]: ch=%0d pc=%h data=%h time=%0d, want ch=%0d pc=%h data=%h time=%0d",
                 cyc, tr_ch, tr_pc, tr_data, tr_time, mq[0].ch, mq[0].pc, mq[0].data, mq[0].ts);
      end
      checks++;
      if (drop_count !== mdrop || done !== mdone || timeout !== mto || exit_code !== mexit || finish !== (mst == 2)) begin
        errors++;
        $display("FAIL rnd_status[%0d]: drops=%0d done=%b timeout=%b exit=%h finish=%b, want %0d/%b/%b/%h/%b",
                 cyc, drop_count, done, timeout, exit_code, finish, mdrop, mdone, mto, mexit, mst == 2);
      end
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_channels();
    test_back_to_back();
    test_host_exit();
    test_timeout();
    test_reset_in_drain();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end
endmodule
